// File: rtl/ghash_pkg.sv
// Shared constants for the GHASH accumulation slice: block width, field
// constants in GCM bit order and the accumulator state encoding.
package ghash_pkg;

  localparam int BLK_W = 128;

  // Bit 127 is the x^0 coefficient, so the identity element is the MSB.
  localparam logic [BLK_W-1:0] GF_ONE = {1'b1, {(BLK_W-1){1'b0}}};
  // Reduction constant applied when x^127 spills over a right shift.
  localparam logic [BLK_W-1:0] GF_R = {8'he1, {(BLK_W-8){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;

endpackage

// File: rtl/gfmul.sv
// GF(2^128) multiplier in GCM bit order with a LAT-deep output pipeline;
// oResult is valid LAT edges after the operands settle.
module gfmul
  import ghash_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic [BLK_W-1:0] iCtext,
  input  logic [BLK_W-1:0] iHashkey,
  output logic [BLK_W-1:0] oResult
);

  logic [BLK_W-1:0] prodComb;

  // Shift-and-add: walk iCtext from x^0 upward while V steps through H*x^i.
  always_comb begin
    logic [BLK_W-1:0] z;
    logic [BLK_W-1:0] v;
    z = '0;
    v = iHashkey;
    for (int i = 0; i < BLK_W; i++) begin
      if (iCtext[BLK_W-1-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    prodComb = z;
  end

  genvar gi;
  for (gi = 0; gi < LAT; gi++) begin : gStage
    logic [BLK_W-1:0] q;
    if (gi == 0) begin : gHead
      always_ff @(posedge clk) q <= prodComb;
    end else begin : gTail
      always_ff @(posedge clk) q <= gStage[gi-1].q;
    end
  end

  assign oResult = gStage[LAT-1].q;

endmodule

// File: rtl/ghash_accum.sv
// GHASH accumulator: folds each block into X through one gfmul instance and
// publishes the final X as the tag after the block flagged last.
module ghash_accum
  import ghash_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClear,
  input  logic [BLK_W-1:0] iHashkey,
  input  logic [BLK_W-1:0] iBlock,
  input  logic             iValid,
  input  logic             iLast,
  output logic             oReady,
  output logic [BLK_W-1:0] oTag,
  output logic             oTagValid,
  output logic             oBusy
);

  logic [1:0]       stateReg;
  logic [BLK_W-1:0] xReg;
  logic [BLK_W-1:0] hReg;
  logic [BLK_W-1:0] operandReg;
  logic [BLK_W-1:0] product;
  logic [CNT_W-1:0] cntReg;
  logic             firstReg;
  logic             lastqReg;

  // A block offered alongside iClear must not be taken.
  assign oReady = (stateReg == IDLE) && !iClear;

  gfmul #(.LAT(MUL_LAT)) uMul (
    .clk      (clk),
    .iCtext   (operandReg),
    .iHashkey (hReg),
    .oResult  (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      xReg       <= '0;
      hReg       <= '0;
      operandReg <= '0;
      cntReg     <= '0;
      firstReg   <= 1'b1;
      lastqReg   <= 1'b0;
      oTag       <= '0;
      oTagValid  <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      oTagValid <= 1'b0;
      if (iClear) begin
        stateReg <= IDLE;
        xReg     <= '0;
        firstReg <= 1'b1;
        oBusy    <= 1'b0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (iValid) begin
              lastqReg <= iLast;
              cntReg   <= CNT_W'(MUL_LAT - 1);
              stateReg <= WAIT;
              // The key is latched once per message; later key changes are ignored.
              if (firstReg) begin
                hReg       <= iHashkey;
                operandReg <= iBlock;
                firstReg   <= 1'b0;
                oBusy      <= 1'b1;
              end else begin
                operandReg <= xReg ^ iBlock;
              end
            end
          end
          WAIT: begin
            if (cntReg == '0) stateReg <= CAPT;
            else              cntReg   <= cntReg - 1'b1;
          end
          CAPT: begin
            stateReg <= IDLE;
            if (lastqReg) begin
              oTag      <= product;
              oTagValid <= 1'b1;
              xReg      <= '0;
              firstReg  <= 1'b1;
              oBusy     <= 1'b0;
            end else begin
              xReg <= product;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghash_accum.sv
// Randomized and directed bench for ghash_accum, checked against a
// polynomial-arithmetic GHASH reference model.
module tb_ghash_accum;

  localparam int MUL_LAT = 2;
  localparam logic [127:0] ONE = 128'h80000000000000000000000000000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iClear = 1'b0;
  logic [127:0] iHashkey = '0;
  logic [127:0] iBlock = '0;
  logic         iValid = 1'b0;
  logic         iLast = 1'b0;
  logic         oReady;
  logic [127:0] oTag;
  logic         oTagValid;
  logic         oBusy;

  int testCount = 0;
  int failCount = 0;
  logic [127:0] msgQ[$];

  always #5 clk = ~clk;

  ghash_accum #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .iClear    (iClear),
    .iHashkey  (iHashkey),
    .iBlock    (iBlock),
    .iValid    (iValid),
    .iLast     (iLast),
    .oReady    (oReady),
    .oTag      (oTag),
    .oTagValid (oTagValid),
    .oBusy     (oBusy)
  );

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Multiply as ordinary polynomials over GF(2), then reduce by x^128+x^7+x^2+x+1.
  function automatic logic [127:0] gfMulRef(input logic [127:0] a, input logic [127:0] b);
    logic [254:0] p;
    logic [254:0] pb;
    logic [254:0] poly;
    logic [127:0] pa;
    pa   = rev128(a);
    pb   = {127'b0, rev128(b)};
    poly = (255'd1 << 128) | 255'h87;
    p    = '0;
    for (int i = 0; i < 128; i++) if (pa[i]) p = p ^ (pb << i);
    for (int i = 254; i >= 128; i--) if (p[i]) p = p ^ (poly << (i - 128));
    return rev128(p[127:0]);
  endfunction

  function automatic logic [127:0] ghashRef(input logic [127:0] h);
    logic [127:0] x;
    x = '0;
    foreach (msgQ[i]) x = gfMulRef(x ^ msgQ[i], h);
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block, then watch oReady and oTagValid for a few cycles after the accept edge.
  task automatic sendBlock(input logic [127:0] blk, input logic [127:0] key, input logic last,
                           output int lowCycles, output int tagAt, output int tagCnt);
    int guard;
    bit stillLow;
    guard = 0;
    @(negedge clk);
    while (!oReady && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!oReady) checkVal("readyTimeout", {127'b0, oReady}, 128'd1);
    iValid = 1'b1; iBlock = blk; iHashkey = key; iLast = last;
    @(posedge clk);
    #1 iValid = 1'b0; iLast = 1'b0;
    lowCycles = 0; tagAt = -1; tagCnt = 0; stillLow = 1'b1;
    for (int j = 0; j <= MUL_LAT + 3; j++) begin
      if (j > 0) @(negedge clk);
      else @(negedge clk);
      if (stillLow && !oReady) lowCycles++;
      else stillLow = 1'b0;
      if (oTagValid) begin
        tagCnt++;
        if (tagAt < 0) tagAt = j;
      end
    end
  endtask

  task automatic runMsg(input string name, input logic [127:0] key, input int gapMax);
    logic [127:0] expTag;
    int low, tagAt, tagCnt;
    bit last;
    expTag = ghashRef(key);
    for (int i = 0; i < msgQ.size(); i++) begin
      repeat ($urandom_range(gapMax, 0)) @(negedge clk);
      last = (i == msgQ.size() - 1);
      sendBlock(msgQ[i], (i == 0) ? key : rand128(), last, low, tagAt, tagCnt);
      checkVal({name, "_readyLow"}, 128'(low), 128'(MUL_LAT + 1));
      if (last) begin
        checkVal({name, "_tagAt"}, 128'(tagAt), 128'(MUL_LAT + 1));
        checkVal({name, "_tagPulse"}, 128'(tagCnt), 128'd1);
        checkVal({name, "_tag"}, oTag, expTag);
        checkVal({name, "_busyEnd"}, {127'b0, oBusy}, 128'd0);
      end else begin
        checkVal({name, "_noTag"}, 128'(tagCnt), 128'd0);
        checkVal({name, "_busy"}, {127'b0, oBusy}, 128'd1);
      end
    end
    $display("[TB] %s: %0d blocks key=%h tag=%h", name, msgQ.size(), key, oTag);
  endtask

  initial begin
    logic [127:0] key;
    logic [127:0] prevTag;
    int low, tagAt, tagCnt, tv, bad;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstTag", oTag, 128'd0);
    checkVal("rstTagValid", {127'b0, oTagValid}, 128'd0);
    checkVal("rstBusy", {127'b0, oBusy}, 128'd0);
    checkVal("rstReady", {127'b0, oReady}, 128'd1);
    rst = 1'b0;

    msgQ = '{128'hfeedfacedeadbeeffeedfacedeadbeef};
    runMsg("identSingle", ONE, 0);
    checkVal("identValue", oTag, 128'hfeedfacedeadbeeffeedfacedeadbeef);

    msgQ = '{128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0};
    runMsg("identPair", ONE, 0);
    checkVal("identPairValue", oTag, {128{1'b1}});

    msgQ = '{128'h0388dace60b6a392f328c2b971b2fe78, 128'h00000000000000000000000000000080};
    runMsg("gcmTc2", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1);
    checkVal("gcmTc2Value", oTag, 128'hf38cbb1ad69223dcc3457ae5b6b0f885);

    msgQ = '{rand128(), rand128(), rand128()};
    runMsg("zeroKey", 128'd0, 2);
    checkVal("zeroKeyValue", oTag, 128'd0);
    msgQ = '{128'h123456789abcdef0123456789abcdef0};
    runMsg("rekey", ONE, 0);
    checkVal("rekeyValue", oTag, 128'h123456789abcdef0123456789abcdef0);

    for (int m = 0; m < 10; m++) begin
      msgQ.delete();
      repeat ($urandom_range(4, 1)) msgQ.push_back(rand128());
      runMsg($sformatf("rand%0d", m), rand128(), 3);
    end

    // Abort during the second block of a three-block message.
    key = rand128();
    prevTag = oTag;
    sendBlock(rand128(), key, 1'b0, low, tagAt, tagCnt);
    @(negedge clk);
    iValid = 1'b1; iBlock = rand128(); iLast = 1'b0; iHashkey = key;
    @(posedge clk);
    #1 iValid = 1'b0;
    @(negedge clk);
    iClear = 1'b1; iValid = 1'b1; iBlock = rand128(); iLast = 1'b1;
    #1 checkVal("clrReadyLow", {127'b0, oReady}, 128'd0);
    @(posedge clk);
    #1 iClear = 1'b0; iValid = 1'b0; iLast = 1'b0;
    @(negedge clk);
    checkVal("clrReadyNext", {127'b0, oReady}, 128'd1);
    checkVal("clrBusy", {127'b0, oBusy}, 128'd0);
    tv = 0;
    repeat (8) begin
      if (oTagValid) tv++;
      @(negedge clk);
    end
    checkVal("clrNoTagValid", 128'(tv), 128'd0);
    checkVal("clrTagHeld", oTag, prevTag);
    $display("[TB] clear: aborted message, tag held at %h", oTag);
    msgQ = '{128'hfeedfacedeadbeeffeedfacedeadbeef};
    runMsg("clrThenSingle", ONE, 0);
    checkVal("clrThenSingleValue", oTag, 128'hfeedfacedeadbeeffeedfacedeadbeef);

    // Asynchronous reset while a block is in the multiplier.
    key = rand128();
    sendBlock(rand128(), key, 1'b0, low, tagAt, tagCnt);
    @(negedge clk);
    iValid = 1'b1; iBlock = rand128(); iLast = 1'b0; iHashkey = key;
    @(posedge clk);
    #1 iValid = 1'b0;
    @(negedge clk);
    checkVal("preRstBusy", {127'b0, oBusy}, 128'd1);
    #1 rst = 1'b1;
    #1;
    checkVal("asyncTag", oTag, 128'd0);
    checkVal("asyncTagValid", {127'b0, oTagValid}, 128'd0);
    checkVal("asyncBusy", {127'b0, oBusy}, 128'd0);
    checkVal("asyncReady", {127'b0, oReady}, 128'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (oTag !== 128'd0 || oTagValid !== 1'b0 || oBusy !== 1'b0 || oReady !== 1'b1) bad++;
    end
    checkVal("idleStable", 128'(bad), 128'd0);
    $display("[TB] async reset: outputs held idle for 20 cycles");
    msgQ = '{128'h123456789abcdef0123456789abcdef0};
    runMsg("postRst", ONE, 1);
    checkVal("postRstValue", oTag, 128'h123456789abcdef0123456789abcdef0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ghash_accum.md
Name: ghash_accum

Overview:
- GHASH accumulation stage that sits directly upstream of gfmul.
- Takes a stream of 128-bit ciphertext/AAD/length blocks and XORs each into the running accumulator X.
- Drives (X xor C) and the hash key into one gfmul instance and feeds each product back into X.
- After the block flagged last (the length block), presents the final X as the GHASH tag for the tag-XOR stage.

Parameters:
- MUL_LAT, 2, clock cycles from gfmul operands being registered to oResult being valid and stable; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- iClear  input  1  synchronous abort; clears the accumulator and returns to IDLE
- iHashkey  input  128  hash key H; sampled on the first accepted block of each message
- iBlock  input  128  data block C_i, in GCM bit order (bit 127 is coefficient x^0)
- iValid  input  1  iBlock is valid
- iLast  input  1  qualifies iBlock as the final block of the message
- oReady  output  1  block accepted on a cycle where iValid and oReady are both high
- oTag  output  128  final GHASH value; holds until the next tag is produced
- oTagValid  output  1  one-cycle pulse when oTag updates
- oBusy  output  1  high from the first accepted block until oTagValid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, X=0, Hreg=0, operand=0, cnt=0, first=1, oReady=1, oTag=0, oTagValid=0, oBusy=0.
- States: IDLE, WAIT, CAPT.
  - IDLE: oReady=1. On accept:
    - operand <= X xor iBlock; lastq <= iLast; cnt <= MUL_LAT-1; go to WAIT.
    - If first=1: Hreg <= iHashkey and operand <= iBlock (X is 0); first <= 0; oBusy <= 1.
  - WAIT: oReady=0. Decrement cnt; when cnt==0, go to CAPT.
  - CAPT: X <= gfmul product (operand, Hreg); oReady=0.
    - If lastq: oTag <= product, oTagValid=1 for the following cycle, X <= 0, first <= 1, oBusy <= 0.
    - Always return to IDLE.
- Timing:
  - Accept at edge E; oReady is high again after edge E+MUL_LAT+1.
  - Throughput: one block per MUL_LAT+2 cycles.
  - oTagValid is asserted in the cycle following edge E+MUL_LAT+1.
- Only one block is in flight; the X feedback dependency forbids overlap.
- gfmul operands come from registers (operand, Hreg) and stay stable for the whole WAIT phase.
- iHashkey changes are ignored between the first block and the last block of a message.
- A single-block message (first block carries iLast) is legal.
- iValid low in IDLE: hold all state indefinitely; no timeout.
- iClear has priority over every transition in every state: X=0, first=1, oBusy=0, go to IDLE, discard any in-flight product.
  - oTag is unchanged and no oTagValid is raised.
  - A block presented in the iClear cycle is not accepted (oReady is forced low that cycle).
- rst mid-message: all registers take their reset values immediately, including oTag=0.
- oTagValid and oReady may be high in the same cycle; a new message may start on that cycle.
- No length counting inside the block; the upstream framer supplies the len(A)||len(C) block with iLast.

Decomposition:
- Shared package ghash_pkg:
  - BLK_W=128.
  - GF_ONE=128'h8000...0 (the multiplicative identity in GCM bit order).
  - State encoding localparams (IDLE, WAIT, CAPT).
- One sub-module, the existing gfmul (clk, iCtext=operand, iHashkey=Hreg, oResult=product), instantiated unchanged.
- MUL_LAT must be set to match gfmul's real pipeline depth.

Test Plan:
1. H=GF_ONE, single block C=feedfacedeadbeeffeedfacedeadbeef with iLast=1 -> oTag=feedfacedeadbeeffeedfacedeadbeef; oTagValid pulses exactly MUL_LAT+2 cycles after accept.
2. H=GF_ONE, blocks 0f0f..0f then f0f0..f0 (last) -> oTag=ffff...ff; oReady is low for MUL_LAT+1 cycles after each accept.
3. GCM test case 2 -> oTag=f38cbb1ad69223dcc3457ae5b6b0f885.
   - Setup: H=66e94bd4ef8a2c3b884cfa59ca342b2e, C=0388dace60b6a392f328c2b971b2fe78, then length block 00000000000000000000000000000080 (last).
4. H=0, any 3 blocks -> oTag=0. Then start a new message with H=GF_ONE and block 1234...def0 (last) -> oTag=123456789abcdef0123456789abcdef0, confirming X cleared and H re-sampled.
5. Assert iClear during WAIT of block 2 of a 3-block message -> no oTagValid, oTag unchanged, oReady=1 next cycle. Then a single-block message behaves as in scenario 1.
6. Assert rst asynchronously mid-WAIT -> oTag, oTagValid and oBusy go to 0 immediately and oReady=1. Hold iValid low with the message incomplete -> outputs remain stable.
